// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int unsigned REG_AW = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;

    // Arbiter state: EMPTY means the hold buffer is free, HELD means it owns one alu write.
    typedef enum logic {
        StEmpty = 1'b0,
        StHeld  = 1'b1
    } arb_state_e;

    // Count up by one, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}}) begin
            return val;
        end
        return CNT_W'(val + 1'b1);
    endfunction

endpackage

// File: rtl/wb_hold_reg.sv
// Single-entry hold buffer for an execute-path write that lost the write port.
module wb_hold_reg
    import wb_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [REG_AW-1:0] dst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [REG_AW-1:0] dst_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [REG_AW-1:0] dst_q;
    logic [DATA_W-1:0] data_q;

    // Load captures a new entry; clear only drops valid so the payload is untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            dst_q   <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            dst_q   <= dst_i;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign dst_o   = dst_q;
    assign data_o  = data_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: load returns always win, a colliding execute
// write is parked in a one-entry buffer and retired on the next free cycle.
module wb_arbiter
    import wb_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    output logic              alu_stall,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CNT_W-1:0]  conflict_cnt,
    output logic              err
);

    arb_state_e        state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              hold_load;
    logic              hold_clear;
    logic              hold_valid;
    logic [REG_AW-1:0] hold_dst;
    logic [DATA_W-1:0] hold_data;
    logic              valid_x;

    wb_hold_reg u_hold (
        .clk     (clk),
        .rst     (rst),
        .load_i  (hold_load),
        .clear_i (hold_clear),
        .dst_i   (alu_dst),
        .data_i  (alu_data),
        .valid_o (hold_valid),
        .dst_o   (hold_dst),
        .data_o  (hold_data)
    );

    // An unknown request strobe only ever matches in four-state simulation.
    assign valid_x = ((alu_valid ^ mem_valid) === 1'bx);

    // Next-state, source selection and buffer control.
    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        cnt_d      = cnt_q;
        err_d      = err_q | valid_x;
        hold_load  = 1'b0;
        hold_clear = 1'b0;

        unique case (state_q)
            StEmpty: begin
                if (mem_valid) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = mem_dst;
                    rf_wdata_d = mem_data;
                    if (alu_valid) begin
                        hold_load = 1'b1;
                        state_d   = StHeld;
                        cnt_d     = sat_inc(cnt_q);
                    end
                end else if (alu_valid) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = alu_dst;
                    rf_wdata_d = alu_data;
                end
            end
            StHeld: begin
                // Upstream must be stalled here; any request is a violation and is dropped.
                if (alu_valid) begin
                    err_d = 1'b1;
                end
                if (mem_valid) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = mem_dst;
                    rf_wdata_d = mem_data;
                end else begin
                    rf_we_d    = hold_valid;
                    rf_waddr_d = hold_dst;
                    rf_wdata_d = hold_data;
                    hold_clear = 1'b1;
                    state_d    = StEmpty;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    // State, registered write port, collision counter and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StEmpty;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign alu_stall    = (state_q == StHeld);
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign conflict_cnt = cnt_q;
    assign err          = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus queues expected writes, a monitor retires them.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [2:0]  alu_dst;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic [2:0]  mem_dst;
    logic [15:0] mem_data;
    logic        alu_stall;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [7:0]  conflict_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Expected register-file writes in issue order: {addr, data}.
    logic [18:0] exp_q[$];

    wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_dst      (alu_dst),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_dst      (mem_dst),
        .mem_data     (mem_data),
        .alu_stall    (alu_stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .conflict_cnt (conflict_cnt),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    // Apply one cycle of requests; returns 1 ns after the edge that samples them.
    task automatic drive(input logic av, input logic [2:0] ad, input logic [15:0] adat,
                         input logic mv, input logic [2:0] md, input logic [15:0] mdat);
        alu_valid = av;
        alu_dst   = ad;
        alu_data  = adat;
        mem_valid = mv;
        mem_dst   = md;
        mem_data  = mdat;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got %0h:%04h expected none", rf_waddr, rf_wdata);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got %0h:%04h expected %0h:%04h",
                             rf_waddr, rf_wdata, e[18:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        rst       = 1'b0;
        alu_valid = 1'b0;
        alu_dst   = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_dst   = '0;
        mem_data  = '0;
        #12;
        chk("reset_we", rf_we, 0);
        chk("reset_waddr", rf_waddr, 0);
        chk("reset_wdata", rf_wdata, 0);
        chk("reset_cnt", conflict_cnt, 0);
        chk("reset_err", err, 0);
        chk("reset_stall", alu_stall, 0);
        @(negedge clk);
        rst = 1'b1;

        // Execute-only write.
        push(3'd3, 16'h1234);
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
        chk("alu_we", rf_we, 1);
        chk("alu_stall", alu_stall, 0);
        idle();
        chk("idle_we", rf_we, 0);
        chk("idle_hold_addr", rf_waddr, 3);
        chk("idle_hold_data", rf_wdata, 16'h1234);

        // Load-only write.
        push(3'd1, 16'h5555);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 16'h5555);
        chk("mem_stall", alu_stall, 0);

        // Simple collision: load first, buffered execute write next.
        push(3'd2, 16'hBEEF);
        push(3'd5, 16'h00AA);
        drive(1'b1, 3'd5, 16'h00AA, 1'b1, 3'd2, 16'hBEEF);
        chk("coll_stall", alu_stall, 1);
        chk("coll_cnt", conflict_cnt, 1);
        idle();
        chk("coll_release_stall", alu_stall, 0);
        chk("coll_release_we", rf_we, 1);
        idle();
        chk("coll_after_we", rf_we, 0);

        // Collision followed by three more load returns.
        push(3'd1, 16'h1111);
        push(3'd6, 16'h6001);
        push(3'd7, 16'h7002);
        push(3'd0, 16'h0003);
        push(3'd4, 16'h4444);
        drive(1'b1, 3'd4, 16'h4444, 1'b1, 3'd1, 16'h1111);
        chk("burst_stall0", alu_stall, 1);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h6001);
        chk("burst_stall1", alu_stall, 1);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'h7002);
        chk("burst_stall2", alu_stall, 1);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'h0003);
        chk("burst_stall3", alu_stall, 1);
        idle();
        chk("burst_release_stall", alu_stall, 0);
        chk("burst_cnt", conflict_cnt, 2);
        idle();

        // Protocol violation while HELD: request dropped, buffer intact.
        push(3'd3, 16'hA0A0);
        push(3'd1, 16'h0B0B);
        push(3'd2, 16'h2222);
        drive(1'b1, 3'd2, 16'h2222, 1'b1, 3'd3, 16'hA0A0);
        chk("viol_err_before", err, 0);
        drive(1'b1, 3'd7, 16'hDEAD, 1'b1, 3'd1, 16'h0B0B);
        chk("viol_err", err, 1);
        chk("viol_stall", alu_stall, 1);
        idle();
        idle();
        chk("viol_err_sticky", err, 1);

        // Saturation: 3 prior collisions + 300 more.
        for (int i = 0; i < 300; i++) begin
            push(3'd0, 16'(i));
            push(3'd1, 16'(~i));
            drive(1'b1, 3'd1, 16'(~i), 1'b1, 3'd0, 16'(i));
            idle();
        end
        chk("sat_cnt", conflict_cnt, 8'hFF);
        chk("sat_err_sticky", err, 1);

        // Reset mid-cycle while HELD: buffered write must be lost.
        push(3'd5, 16'h5A5A);
        drive(1'b1, 3'd6, 16'h6B6B, 1'b1, 3'd5, 16'h5A5A);
        chk("rst_pre_stall", alu_stall, 1);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_cnt", conflict_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", alu_stall, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        idle();
        idle();
        idle();
        chk("post_rst_we", rf_we, 0);

        // Normal operation right after release.
        push(3'd3, 16'h3333);
        drive(1'b1, 3'd3, 16'h3333, 1'b0, 3'd0, 16'h0);
        chk("post_rst_alu_we", rf_we, 1);
        idle();
        idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 alu_valid  in  1  execute-path write request (ALU, set, link or immediate result).
REQ-005 alu_dst  in  3  execute-path destination register.
REQ-006 alu_data  in  16  execute-path write data.
REQ-007 mem_valid  in  1  multi-cycle load-return write request; cannot be stalled.
REQ-008 mem_dst  in  3  load destination register.
REQ-009 mem_data  in  16  load data.
REQ-010 alu_stall  out  1  back-pressure to execute; while 1, upstream SHALL NOT assert alu_valid.
REQ-011 rf_we  out  1  registered register-file write enable.
REQ-012 rf_waddr  out  3  registered write address.
REQ-013 rf_wdata  out  16  registered write data.
REQ-014 conflict_cnt  out  8  saturating count of write-port collisions.
REQ-015 err  out  1  sticky protocol-violation flag.

Function
REQ-016 The state machine SHALL have two states: EMPTY (hold buffer invalid) and HELD (hold buffer contains one execute-path write).
REQ-017 alu_stall SHALL equal (state == HELD) and SHALL be decoded from state only, with no combinational path from any input.
REQ-018 The rf_* outputs SHALL be registered, so a write accepted in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1 for exactly one cycle per accepted write.
REQ-019 EMPTY, mem_valid=1 and alu_valid=0: the block SHALL issue the mem write and remain in EMPTY.
REQ-020 EMPTY, alu_valid=1 and mem_valid=0: the block SHALL issue the alu write and remain in EMPTY.
REQ-021 EMPTY, both valid: the block SHALL issue the mem write, capture alu_dst/alu_data into the hold buffer, move to HELD and increment conflict_cnt.
REQ-022 EMPTY, neither valid: the block SHALL set rf_we=0 next cycle.
REQ-023 HELD, mem_valid=1: the block SHALL issue the mem write, keep the buffer and remain in HELD.
REQ-024 HELD, mem_valid=0: the block SHALL issue the buffered write and return to EMPTY.
REQ-025 HELD, alu_valid=1: the block SHALL set err, drop the request and leave the buffer unchanged.
REQ-026 A mem return SHALL always win the write port; ordering contract: the hazard unit guarantees any buffered write is younger than a concurrent load return, so mem-then-buffer order is architecturally correct.
REQ-027 When rf_we=0, rf_waddr and rf_wdata SHALL hold their previous values.
REQ-028 conflict_cnt SHALL saturate at 8'hFF and never wrap.
REQ-029 An X on alu_valid or mem_valid SHALL set err in simulation.
REQ-030 err SHALL be cleared only by reset.

Reset
REQ-031 Asserting rst SHALL asynchronously force state=EMPTY, buffer valid=0, rf_we=0, rf_waddr=3'b0, rf_wdata=16'h0000, conflict_cnt=8'h00, err=0 and alu_stall=0.
REQ-032 Reset in HELD SHALL discard the buffered write with no rf write issued.
REQ-033 Reset deassertion SHALL be followed by normal operation from the first rising edge.

Structure
REQ-034 Package wb_arb_pkg SHALL hold the state encoding (EMPTY=1'b0, HELD=1'b1), REG_AW=3, DATA_W=16 and CNT_W=8.
REQ-035 The hold buffer SHALL be a sub-module, wb_hold_reg: single-entry {valid, dst, data} register with load and clear.
REQ-036 The top level SHALL contain the FSM, source mux, output registers and counter.

Verification
REQ-037 Bench: alu_valid only, dst=3, data=16'h1234 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h1234; alu_stall stays 0.
REQ-038 Bench: both valid (mem dst=2, 16'hBEEF; alu dst=5, 16'h00AA) -> cycle+1: write r2=BEEF, alu_stall=1, conflict_cnt=1; cycle+2: write r5=00AA, alu_stall=0.
REQ-039 Bench: collision, then mem_valid held 3 more cycles -> 4 mem writes in order, then buffered write, alu_stall=1 throughout.
REQ-040 Bench: alu_valid during HELD -> err=1 and stays 1; buffered data written unchanged; dropped request never written.
REQ-041 Bench: 300 collisions -> conflict_cnt=8'hFF.
REQ-042 Bench: rst asserted mid-clock in HELD -> outputs immediately at reset values; no buffered write after release.
